// File: rtl/spi_slave_regs.sv
// spi_slave_regs: SPI mode-0 responder with an 8 x 8-bit register file.
// SCK, SS_N and MOSI are oversampled on the system clock. Register 7 is a
// read-only ID. Every committed write is echoed on a one-clock strobe port.
module spi_slave_regs #(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] RESET_VAL   = 8'h00,
    parameter logic [7:0] ID_VALUE    = 8'hA5
) (
    input  logic       spi_wb_clk_i,
    input  logic       spi_wb_rst_i,
    input  logic       sck_i,
    input  logic       ss_n_i,
    input  logic       mosi_i,
    output logic       miso_o,
    output logic       miso_oe,
    output logic       wr_strobe_o,
    output logic [2:0] wr_addr_o,
    output logic [7:0] wr_data_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_WR   = 2'd2,
        ST_RD   = 2'd3
    } state_t;

    state_t state_r;
    state_t state_next_s;

    logic [SYNC_STAGES-1:0] sck_sync_r;
    logic [SYNC_STAGES-1:0] ss_sync_r;
    logic [SYNC_STAGES-1:0] mosi_sync_r;
    logic                   sck_prev_r;
    logic                   ss_prev_r;

    logic sck_s, ss_s, mosi_s;
    logic sck_rise_s, sck_fall_s, ss_fall_s, ss_rise_s;

    logic [2:0] bit_cnt_r;      // bits received in the current MOSI byte
    logic [7:0] shift_r;        // MOSI shift register
    logic [2:0] addr_r;         // current register address
    logic [7:0] tx_r;           // MISO shift register, MSB is on the wire
    logic [2:0] tx_cnt_r;       // 0 means the next SCK fall loads a new byte
    logic       commit_pend_r;  // full data byte waiting to be written

    logic [7:0] regs_r [7];
    logic [7:0] rd_data_s;
    logic       miso_s;
    logic       miso_oe_s;

    // Synchronizer chains plus the edge-detect flops for SCK and SS_N
    always_ff @(posedge spi_wb_clk_i or posedge spi_wb_rst_i) begin
        if (spi_wb_rst_i) begin
            sck_sync_r  <= '0;
            ss_sync_r   <= '1;
            mosi_sync_r <= '0;
            sck_prev_r  <= 1'b0;
            ss_prev_r   <= 1'b1;
        end else begin
            sck_sync_r  <= {sck_sync_r[SYNC_STAGES-2:0], sck_i};
            ss_sync_r   <= {ss_sync_r[SYNC_STAGES-2:0], ss_n_i};
            mosi_sync_r <= {mosi_sync_r[SYNC_STAGES-2:0], mosi_i};
            sck_prev_r  <= sck_sync_r[SYNC_STAGES-1];
            ss_prev_r   <= ss_sync_r[SYNC_STAGES-1];
        end
    end

    assign sck_s      = sck_sync_r[SYNC_STAGES-1];
    assign ss_s       = ss_sync_r[SYNC_STAGES-1];
    assign mosi_s     = mosi_sync_r[SYNC_STAGES-1];
    assign sck_rise_s = sck_s & ~sck_prev_r;
    assign sck_fall_s = ~sck_s & sck_prev_r;
    assign ss_fall_s  = ~ss_s & ss_prev_r;
    assign ss_rise_s  = ss_s & ~ss_prev_r;

    // Read mux: register 7 always returns the ID constant
    always_comb begin
        rd_data_s = ID_VALUE;
        case (addr_r)
            3'd0:    rd_data_s = regs_r[0];
            3'd1:    rd_data_s = regs_r[1];
            3'd2:    rd_data_s = regs_r[2];
            3'd3:    rd_data_s = regs_r[3];
            3'd4:    rd_data_s = regs_r[4];
            3'd5:    rd_data_s = regs_r[5];
            3'd6:    rd_data_s = regs_r[6];
            default: rd_data_s = ID_VALUE;
        endcase
    end

    // FSM state register
    always_ff @(posedge spi_wb_clk_i or posedge spi_wb_rst_i) begin
        if (spi_wb_rst_i) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next-state logic; SS_N rise beats any simultaneous SCK edge
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (ss_fall_s) begin
                    state_next_s = ST_CMD;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_CMD: begin
                if (ss_rise_s) begin
                    state_next_s = ST_IDLE;
                end else if (sck_rise_s && (bit_cnt_r == 3'd7)) begin
                    state_next_s = shift_r[6] ? ST_RD : ST_WR;
                end else begin
                    state_next_s = ST_CMD;
                end
            end
            ST_WR, ST_RD: begin
                if (ss_rise_s) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = state_r;
                end
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // FSM output decode: MISO carries tx data only while reading
    always_comb begin
        miso_s    = 1'b0;
        miso_oe_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                miso_s    = 1'b0;
                miso_oe_s = 1'b0;
            end
            ST_CMD, ST_WR: begin
                miso_s    = 1'b0;
                miso_oe_s = 1'b1;
            end
            ST_RD: begin
                miso_s    = tx_r[7];
                miso_oe_s = 1'b1;
            end
            default: begin
                miso_s    = 1'b0;
                miso_oe_s = 1'b0;
            end
        endcase
    end

    // Registered MISO and its output enable
    always_ff @(posedge spi_wb_clk_i or posedge spi_wb_rst_i) begin
        if (spi_wb_rst_i) begin
            miso_o  <= 1'b0;
            miso_oe <= 1'b0;
        end else begin
            miso_o  <= miso_s;
            miso_oe <= miso_oe_s;
        end
    end

    // Bit counting, shift registers and address sequencing
    always_ff @(posedge spi_wb_clk_i or posedge spi_wb_rst_i) begin
        if (spi_wb_rst_i) begin
            bit_cnt_r     <= 3'd0;
            shift_r       <= 8'h00;
            addr_r        <= 3'd0;
            tx_r          <= 8'h00;
            tx_cnt_r      <= 3'd0;
            commit_pend_r <= 1'b0;
        end else begin
            // A completed byte commits one clock after its 8th bit, even if
            // SS_N rises meanwhile; the address moves on with it.
            if (commit_pend_r) begin
                commit_pend_r <= 1'b0;
                addr_r        <= addr_r + 3'd1;
            end
            if (state_r == ST_IDLE) begin
                if (ss_fall_s) begin
                    bit_cnt_r <= 3'd0;
                    shift_r   <= 8'h00;
                    tx_r      <= 8'h00;
                    tx_cnt_r  <= 3'd0;
                end
            end else if (ss_rise_s) begin
                // Partial byte is simply dropped
                bit_cnt_r <= 3'd0;
                tx_cnt_r  <= 3'd0;
            end else begin
                if (sck_rise_s && ((state_r == ST_CMD) || (state_r == ST_WR))) begin
                    shift_r   <= {shift_r[6:0], mosi_s};
                    bit_cnt_r <= bit_cnt_r + 3'd1;
                    if (bit_cnt_r == 3'd7) begin
                        if (state_r == ST_CMD) begin
                            addr_r <= {shift_r[1:0], mosi_s};
                        end else begin
                            commit_pend_r <= 1'b1;
                        end
                    end
                end
                if (sck_fall_s && (state_r == ST_RD)) begin
                    if (tx_cnt_r == 3'd0) begin
                        tx_r     <= rd_data_s;
                        tx_cnt_r <= 3'd1;
                    end else begin
                        tx_r     <= {tx_r[6:0], 1'b0};
                        tx_cnt_r <= tx_cnt_r + 3'd1;
                        if (tx_cnt_r == 3'd7) begin
                            addr_r <= addr_r + 3'd1;
                        end
                    end
                end
            end
        end
    end

    // Register file write and write-strobe port; address 7 is read-only
    always_ff @(posedge spi_wb_clk_i or posedge spi_wb_rst_i) begin
        if (spi_wb_rst_i) begin
            for (int i = 0; i < 7; i++) begin
                regs_r[i] <= RESET_VAL;
            end
            wr_strobe_o <= 1'b0;
            wr_addr_o   <= 3'd0;
            wr_data_o   <= 8'h00;
        end else begin
            wr_strobe_o <= 1'b0;
            if (commit_pend_r && (addr_r != 3'd7)) begin
                regs_r[addr_r] <= shift_r;
                wr_strobe_o    <= 1'b1;
                wr_addr_o      <= addr_r;
                wr_data_o      <= shift_r;
            end
        end
    end

endmodule
